// File: rtl/serial_xnor_compare.sv
// Bit-serial word comparator.
// Takes one a/b bit pair per qualified cycle (LSB first), forms the per-bit
// equivalence, counts matching positions and records the lowest mismatching
// index. After WIDTH valid bits the word-level results are published together
// with a one-cycle done pulse. All outputs come straight from flops.
module serial_xnor_compare #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          bit_valid,
    input  logic          a,
    input  logic          b,
    output logic          ready,
    output logic          done,
    output logic          equal,
    output logic [CW-1:0] match_count,
    output logic [CW-1:0] first_mismatch
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // WIDTH doubles as the "no mismatch seen yet" marker for first_mismatch.
    localparam logic [CW-1:0] WIDTH_C  = CW'(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [CW-1:0] ZERO_C   = CW'(0);

    state_t        state_r;
    logic [CW-1:0] bit_idx_r;
    logic [CW-1:0] work_cnt_r;
    logic [CW-1:0] work_fm_r;

    logic          eq_s;
    logic          last_bit_s;
    logic [CW-1:0] cnt_next_s;
    logic [CW-1:0] fm_next_s;

    // Equivalence of one bit pair, the same function as the upstream XNOR stage.
    function automatic logic equiv_bit(input logic x, input logic y);
        return ~(x ^ y);
    endfunction

    // Working values as they would be after absorbing the current bit pair.
    always_comb begin
        eq_s       = equiv_bit(a, b);
        last_bit_s = (bit_idx_r == LAST_IDX);
        cnt_next_s = work_cnt_r + {{(CW-1){1'b0}}, eq_s};
        if (!eq_s && (work_fm_r == WIDTH_C)) begin
            fm_next_s = bit_idx_r;
        end else begin
            fm_next_s = work_fm_r;
        end
    end

    // Control FSM, working accumulators and registered outputs. Results are
    // loaded on the edge that samples the last bit so they are already visible
    // in the DONE cycle alongside the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            bit_idx_r      <= ZERO_C;
            work_cnt_r     <= ZERO_C;
            work_fm_r      <= WIDTH_C;
            ready          <= 1'b1;
            done           <= 1'b0;
            equal          <= 1'b0;
            match_count    <= ZERO_C;
            first_mismatch <= ZERO_C;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r    <= ST_SHIFT;
                        ready      <= 1'b0;
                        bit_idx_r  <= ZERO_C;
                        work_cnt_r <= ZERO_C;
                        work_fm_r  <= WIDTH_C;
                    end else begin
                        state_r <= ST_IDLE;
                        ready   <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    done  <= 1'b0;
                    ready <= 1'b0;
                    if (bit_valid) begin
                        work_cnt_r <= cnt_next_s;
                        work_fm_r  <= fm_next_s;
                        if (last_bit_s) begin
                            // Index stays at WIDTH-1 so it can never wrap.
                            state_r        <= ST_DONE;
                            done           <= 1'b1;
                            equal          <= (cnt_next_s == WIDTH_C);
                            match_count    <= cnt_next_s;
                            first_mismatch <= fm_next_s;
                        end else begin
                            bit_idx_r <= bit_idx_r + ONE_C;
                        end
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    // start is deliberately ignored here; IDLE follows unconditionally.
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                    ready   <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_xnor_compare.sv
// Directed, table-driven bench for serial_xnor_compare (WIDTH = 8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_xnor_compare;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          bit_valid;
    logic          a;
    logic          b;
    logic          ready;
    logic          done;
    logic          equal;
    logic [CW-1:0] match_count;
    logic [CW-1:0] first_mismatch;

    int checks   = 0;
    int failures = 0;

    // Results the outputs must hold until the next done.
    logic          prev_eq;
    logic [CW-1:0] prev_mc;
    logic [CW-1:0] prev_fm;

    typedef struct {
        logic [7:0]    av;
        logic [7:0]    bv;
        bit            gap;
        bit            hold;
        logic          e_eq;
        logic [CW-1:0] e_mc;
        logic [CW-1:0] e_fm;
    } vec_t;

    vec_t vecs [5];

    serial_xnor_compare #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .bit_valid      (bit_valid),
        .a              (a),
        .b              (b),
        .ready          (ready),
        .done           (done),
        .equal          (equal),
        .match_count    (match_count),
        .first_mismatch (first_mismatch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_held(input string tag);
        chk({tag, "_equal_held"}, equal, prev_eq);
        chk({tag, "_count_held"}, match_count, prev_mc);
        chk({tag, "_fm_held"}, first_mismatch, prev_fm);
    endtask

    // Runs one word starting at a falling edge while the DUT is idle.
    // gap: bit_valid only on odd cycles after acceptance.
    // hold: start kept high through SHIFT and the DONE cycle.
    task automatic run_word(input logic [7:0] av, input logic [7:0] bv, input bit gap,
                            input bit hold, input logic e_eq,
                            input logic [CW-1:0] e_mc, input logic [CW-1:0] e_fm);
        int cyc;
        int bi;
        chk("ready_idle", ready, 1);
        start     = 1'b1;
        bit_valid = 1'b1;
        a         = ~av[0];
        b         = av[0];           // a mismatching pair that must be ignored
        @(negedge clk);
        cyc   = 1;
        start = hold;
        chk("ready_shift", ready, 0);
        bi = 0;
        while (bi < W) begin
            chk("no_early_done", done, 0);
            chk("ready_low", ready, 0);
            chk_held("shift");
            if (!gap || (cyc % 2 == 1)) begin
                bit_valid = 1'b1;
                a         = av[bi];
                b         = bv[bi];
                bi++;
            end else begin
                bit_valid = 1'b0;
                a         = 1'b1;
                b         = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        // DONE cycle: t+9 continuous, t+16 gapped
        bit_valid = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        chk("done_pulse", done, 1);
        chk("ready_in_done", ready, 0);
        chk("equal", equal, e_eq);
        chk("match_count", match_count, e_mc);
        chk("first_mismatch", first_mismatch, e_fm);
        @(negedge clk);
        start   = 1'b0;
        prev_eq = e_eq;
        prev_mc = e_mc;
        prev_fm = e_fm;
        chk("done_one_cycle", done, 0);
        chk("ready_back", ready, 1);
        chk_held("after");
        if (hold) begin
            @(negedge clk);
            chk("no_queued_start", ready, 1);
            chk("no_queued_done", done, 0);
        end
    endtask

    initial begin
        vecs[0] = '{av: 8'hA5, bv: 8'hA5, gap: 1'b0, hold: 1'b0, e_eq: 1'b1, e_mc: 4'd8, e_fm: 4'd8};
        vecs[1] = '{av: 8'hA5, bv: 8'hA4, gap: 1'b0, hold: 1'b0, e_eq: 1'b0, e_mc: 4'd7, e_fm: 4'd0};
        vecs[2] = '{av: 8'h0F, bv: 8'h8F, gap: 1'b0, hold: 1'b1, e_eq: 1'b0, e_mc: 4'd7, e_fm: 4'd7};
        vecs[3] = '{av: 8'h00, bv: 8'hFF, gap: 1'b0, hold: 1'b0, e_eq: 1'b0, e_mc: 4'd0, e_fm: 4'd0};
        vecs[4] = '{av: 8'h3C, bv: 8'h3C, gap: 1'b1, hold: 1'b0, e_eq: 1'b1, e_mc: 4'd8, e_fm: 4'd8};

        rst       = 1'b1;
        start     = 1'b0;
        bit_valid = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        prev_eq   = 1'b0;
        prev_mc   = '0;
        prev_fm   = '0;

        #12;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_equal", equal, 0);
        chk("rst_count", match_count, 0);
        chk("rst_fm", first_mismatch, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Words run back to back: each starts in the first idle cycle.
        for (int i = 0; i < 5; i++) begin
            run_word(vecs[i].av, vecs[i].bv, vecs[i].gap, vecs[i].hold,
                     vecs[i].e_eq, vecs[i].e_mc, vecs[i].e_fm);
        end

        // Reset in the middle of a word.
        chk("ready_pre_abort", ready, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            a         = 1'b1;
            b         = 1'b1;
            @(negedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_equal", equal, 0);
        chk("mid_rst_count", match_count, 0);
        chk("mid_rst_fm", first_mismatch, 0);
        @(negedge clk);
        rst       = 1'b0;
        bit_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = 1'b1;
            b = 1'b1;
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_ready", ready, 1);
        end
        bit_valid = 1'b0;
        prev_eq   = 1'b0;
        prev_mc   = '0;
        prev_fm   = '0;
        run_word(8'h12, 8'h13, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_xnor_compare.md
# serial_xnor_compare

Bit-serial word comparator that consumes a per-bit XNOR (equivalence) result stream and reduces it to word-level equality information. It sits directly downstream of the NAND-built XNOR stage. Each cycle it takes one bit pair `a`/`b`, forms their equivalence, counts matching bits, and records the index of the first mismatch. After `WIDTH` valid bits it reports the result with a one-cycle `done` pulse.

## Interface
Parameters:
- `WIDTH`, default 8, bits per word; legal range 2..32. `CW` = `$clog2(WIDTH+1)` is derived, not overridable.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a word; accepted only when `ready`=1.
- `bit_valid`  in  1  qualifies `a`/`b` this cycle.
- `a`  in  1  serial operand A bit, LSB first.
- `b`  in  1  serial operand B bit, LSB first.
- `ready`  out  1  high in IDLE only.
- `done`  out  1  one-cycle pulse when results update.
- `equal`  out  1  1 when all `WIDTH` bits matched.
- `match_count`  out  CW  number of bit positions where `a`==`b`.
- `first_mismatch`  out  CW  index (0-based, LSB = 0) of the lowest mismatching bit; `WIDTH` if there is none.

## Operation
- Per-bit equivalence is `e = ~(a ^ b)`.
- States:
  - IDLE: `ready`=1. `start`=1 → SHIFT; clear the working bit index, working match counter, and working first-mismatch (set to `WIDTH`). `a`/`b`/`bit_valid` are ignored in IDLE, including in the `start` cycle.
  - SHIFT: on each cycle with `bit_valid`=1:
    - Working match counter += `e`.
    - If `e`=0 and working first-mismatch == `WIDTH`, load the current bit index.
    - Bit index increments.
    - On the valid bit with index == `WIDTH-1`, go to DONE.
    - Cycles with `bit_valid`=0 change nothing.
  - DONE: output registers load from the working values. `equal` = (working count == `WIDTH`). `done`=1. Next state is IDLE unconditionally.
- Output registers `equal`, `match_count`, `first_mismatch` hold the previous word's results through SHIFT and until the next DONE.
- `start` outside IDLE is ignored; it is neither queued nor does it restart the word.
- No counter can wrap: the bit index saturates at the transition to DONE, and the count is at most `WIDTH`, which fits in `CW`.
- Reset (any state, including mid-word): state goes to IDLE immediately. `ready`=1, `done`=0, `equal`=0, `match_count`=0, `first_mismatch`=0. Partial word data is discarded and no `done` is issued.

## Timing
- `start` sampled high at edge t (with `ready`=1) → SHIFT from t+1. `ready` drops to 0 at t+1.
- First bit is sampled at edge t+1 at the earliest.
- With continuous `bit_valid`:
  - Last bit is sampled at t+`WIDTH`.
  - DONE occurs in cycle t+`WIDTH`+1; `done` and the new results are visible in that cycle.
  - `ready` returns to 1 at t+`WIDTH`+2.
- General latency: `done` asserts one cycle after the edge that samples the `WIDTH`-th valid bit.
- `ready` is 0 during both SHIFT and DONE.
- `start` asserted during the DONE cycle is ignored. `start` in the following (IDLE) cycle is accepted.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use `WIDTH`=8; t is the edge that accepts `start`.
- Reset: assert `rst` asynchronously mid-cycle → outputs immediately become `ready`=1, `done`=0, `equal`=0, `match_count`=0, `first_mismatch`=0.
- Equal words: A=B=0xA5, LSB first, continuous `bit_valid` → `done`=1 only in cycle t+9. `equal`=1, `match_count`=8, `first_mismatch`=8. `ready`=1 at t+10.
- Mismatch cases:
  - A=0xA5, B=0xA4 → `equal`=0, `match_count`=7, `first_mismatch`=0.
  - A=0x0F, B=0x8F → `match_count`=7, `first_mismatch`=7.
  - A=0x00, B=0xFF → `match_count`=0, `first_mismatch`=0.
- Gapped valid: A=B=0x3C with `bit_valid` high only on alternate cycles starting at t+1 → bits sampled at t+1, t+3, …, t+15. `done` at t+16; results identical to continuous streaming. Previous results remain stable throughout.
- Start handling:
  - `start` held high during SHIFT and during the DONE cycle → neither restarts nor queues a word.
  - `start` at t+10 (after a word ending at t+9) → accepted; the second word compares correctly.
- Reset mid-word: assert `rst` after 4 valid bits → no `done` is issued and outputs take reset values. A new word A=0x12, B=0x13 then gives `match_count`=7, `first_mismatch`=0.
